victim_cache: RTL and testbench



---
 rtl/victim_cache_pkg.sv | 20 ++
 rtl/victim_cache_if.sv | 35 +++
 rtl/victim_cache_line_array.sv | 30 +++
 rtl/victim_cache.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_victim_cache.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/victim_cache_pkg.sv
// Shared types and default geometry for the victim cache.
//   VC_WIDTH / VC_DEPTH / VC_TAG_W : default line width, entry count, tag width
//   lc3b_vc_tag                    : line-address (tag) type
//   vc_state_t                     : controller FSM states
package victim_cache_pkg;

    localparam int unsigned VC_WIDTH = 128;
    localparam int unsigned VC_DEPTH = 8;
    localparam int unsigned VC_TAG_W = 12;

    typedef logic [VC_TAG_W-1:0] lc3b_vc_tag;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WB     = 2'd2,
        RESP   = 2'd3
    } vc_state_t;

endpackage

// File: rtl/victim_cache_if.sv
// Request/response and writeback bundle of the victim cache.
//   master : L1 side plus memory acknowledge (drives requests and wb_resp)
//   slave  : the victim cache itself
interface victim_cache_if #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned TAG_W = 12
);

    logic             lookup_req;
    logic [TAG_W-1:0] lookup_tag;
    logic             evict_valid;
    logic [TAG_W-1:0] evict_tag;
    logic [WIDTH-1:0] evict_data;
    logic             evict_dirty;
    logic             busy;
    logic             resp;
    logic             lookup_hit;
    logic [WIDTH-1:0] lookup_data;
    logic             lookup_dirty;
    logic             wb_write;
    logic [TAG_W-1:0] wb_tag;
    logic [WIDTH-1:0] wb_data;
    logic             wb_resp;

    modport master (
        output lookup_req, lookup_tag, evict_valid, evict_tag, evict_data, evict_dirty, wb_resp,
        input  busy, resp, lookup_hit, lookup_data, lookup_dirty, wb_write, wb_tag, wb_data
    );

    modport slave (
        input  lookup_req, lookup_tag, evict_valid, evict_tag, evict_data, evict_dirty, wb_resp,
        output busy, resp, lookup_hit, lookup_data, lookup_dirty, wb_write, wb_tag, wb_data
    );

endinterface

// File: rtl/victim_cache_line_array.sv
// vc_line_array: DEPTH x WIDTH line storage, one synchronous write port and
// one combinational indexed read port.
//   clk         : clock
//   we/waddr    : write enable and slot index
//   wdata       : line written at the clock edge
//   raddr/rdata : read slot index and its current contents
module vc_line_array #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Line contents need no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/victim_cache.sv
// victim_cache: fully associative victim cache between L1 and memory.
// Holds L1 evictions, returns-and-removes a line on an L1-miss hit, absorbs
// the accompanying eviction, keeps true-LRU ages and writes back dirty lines
// before they are overwritten.
//   clk, rst : clock, synchronous active-high reset
//   vc       : victim_cache_if slave (requests, result, writeback handshake)
module victim_cache
    import victim_cache_pkg::*;
#(
    parameter int unsigned WIDTH = VC_WIDTH,
    parameter int unsigned DEPTH = VC_DEPTH,
    parameter int unsigned TAG_W = VC_TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    victim_cache_if.slave vc
);

    localparam int unsigned      IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH - 1);

    vc_state_t state_q, state_d;

    // Captured request
    logic             lk_req_q, lk_req_d;
    logic [TAG_W-1:0] lk_tag_q, lk_tag_d;
    logic             ev_valid_q, ev_valid_d;
    logic [TAG_W-1:0] ev_tag_q, ev_tag_d;
    logic [WIDTH-1:0] ev_data_q, ev_data_d;
    logic             ev_dirty_q, ev_dirty_d;

    // Per-entry state
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [IDX_W-1:0] age_q [DEPTH];
    logic [IDX_W-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] dirty_q, dirty_d;

    // Registered outputs and pending install slot
    logic             busy_q, busy_d;
    logic             resp_q, resp_d;
    logic             hit_q, hit_d;
    logic [WIDTH-1:0] hit_data_q, hit_data_d;
    logic             hit_dirty_q, hit_dirty_d;
    logic             wb_write_q, wb_write_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [IDX_W-1:0] slot_q, slot_d;

    // Search results
    logic             lk_hit, ev_hit, inv_any, need_wb;
    logic [IDX_W-1:0] lk_idx, ev_idx, inv_idx, lru_idx, tgt_idx, rd_idx;
    logic [WIDTH-1:0] rd_data;

    // Array update controls
    logic             inst_en, inval_en, inst_dirty, line_we;
    logic [IDX_W-1:0] upd_slot, old_age;

    vc_line_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lines (
        .clk   (clk),
        .we    (line_we),
        .waddr (upd_slot),
        .wdata (ev_data_q),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // CAM compare and victim selection; descending scan leaves the lowest index.
    always_comb begin : cam
        lk_hit  = 1'b0;
        lk_idx  = '0;
        ev_hit  = 1'b0;
        ev_idx  = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        lru_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == lk_tag_q)) begin
                lk_hit = lk_req_q;
                lk_idx = IDX_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == ev_tag_q)) begin
                ev_hit = 1'b1;
                ev_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
            if (age_q[i] == AGE_MAX) begin
                lru_idx = IDX_W'(i);
            end
        end
        tgt_idx = ev_hit ? ev_idx : (inv_any ? inv_idx : lru_idx);
        rd_idx  = lk_hit ? lk_idx : tgt_idx;
        // No invalid slot means the LRU slot is valid; only a dirty one needs writeback.
        need_wb = ev_valid_q && !lk_hit && !ev_hit && !inv_any && dirty_q[lru_idx];
    end

    // Controller: request capture, search decision, writeback handshake, response.
    always_comb begin : fsm_next
        state_d     = state_q;
        lk_req_d    = lk_req_q;
        lk_tag_d    = lk_tag_q;
        ev_valid_d  = ev_valid_q;
        ev_tag_d    = ev_tag_q;
        ev_data_d   = ev_data_q;
        ev_dirty_d  = ev_dirty_q;
        busy_d      = busy_q;
        resp_d      = 1'b0;
        hit_d       = hit_q;
        hit_data_d  = hit_data_q;
        hit_dirty_d = hit_dirty_q;
        wb_write_d  = wb_write_q;
        wb_tag_d    = wb_tag_q;
        wb_data_d   = wb_data_q;
        slot_d      = slot_q;
        inst_en     = 1'b0;
        inval_en    = 1'b0;
        inst_dirty  = ev_dirty_q;
        upd_slot    = tgt_idx;

        unique case (state_q)
            IDLE: begin
                if (vc.lookup_req || vc.evict_valid) begin
                    lk_req_d   = vc.lookup_req;
                    lk_tag_d   = vc.lookup_tag;
                    ev_valid_d = vc.evict_valid;
                    ev_tag_d   = vc.evict_tag;
                    ev_data_d  = vc.evict_data;
                    ev_dirty_d = vc.evict_dirty;
                    busy_d     = 1'b1;
                    state_d    = SEARCH;
                end
            end
            SEARCH: begin
                hit_d       = lk_hit;
                hit_data_d  = lk_hit ? rd_data : '0;
                hit_dirty_d = lk_hit && dirty_q[lk_idx];
                if (lk_hit) begin
                    // Hit line leaves the cache; the eviction (if any) takes its slot.
                    upd_slot = lk_idx;
                    inst_en  = ev_valid_q;
                    inval_en = !ev_valid_q;
                    resp_d   = 1'b1;
                    state_d  = RESP;
                end else if (need_wb) begin
                    wb_write_d = 1'b1;
                    wb_tag_d   = tag_q[tgt_idx];
                    wb_data_d  = rd_data;
                    slot_d     = tgt_idx;
                    state_d    = WB;
                end else begin
                    // Same-tag refresh keeps any dirtiness already recorded.
                    inst_en    = ev_valid_q;
                    inst_dirty = ev_dirty_q || (ev_hit && dirty_q[tgt_idx]);
                    resp_d     = 1'b1;
                    state_d    = RESP;
                end
            end
            WB: begin
                upd_slot = slot_q;
                if (vc.wb_resp) begin
                    wb_write_d = 1'b0;
                    inst_en    = 1'b1;
                    resp_d     = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag/valid/dirty next state.
    always_comb begin : entry_next
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (inst_en) begin
            tag_d[upd_slot]   = ev_tag_q;
            valid_d[upd_slot] = 1'b1;
            dirty_d[upd_slot] = inst_dirty;
        end
        if (inval_en) begin
            valid_d[upd_slot] = 1'b0;
            dirty_d[upd_slot] = 1'b0;
        end
    end

    // True-LRU ages: install moves to age 0, invalidate moves to the oldest age,
    // shifting the others so the ages stay a permutation.
    always_comb begin : age_next
        age_d   = age_q;
        old_age = age_q[upd_slot];
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (inst_en) begin
                if (IDX_W'(i) == upd_slot) begin
                    age_d[i] = '0;
                end else if (age_q[i] < old_age) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end else if (inval_en) begin
                if (IDX_W'(i) == upd_slot) begin
                    age_d[i] = AGE_MAX;
                end else if (age_q[i] > old_age) begin
                    age_d[i] = age_q[i] - IDX_W'(1);
                end
            end
        end
    end

    // A reset during WB must not let the pending install reach the line array.
    assign line_we = inst_en && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lk_req_q    <= 1'b0;
            lk_tag_q    <= '0;
            ev_valid_q  <= 1'b0;
            ev_tag_q    <= '0;
            ev_data_q   <= '0;
            ev_dirty_q  <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
            busy_q      <= 1'b0;
            resp_q      <= 1'b0;
            hit_q       <= 1'b0;
            hit_data_q  <= '0;
            hit_dirty_q <= 1'b0;
            wb_write_q  <= 1'b0;
            wb_tag_q    <= '0;
            wb_data_q   <= '0;
            slot_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            state_q     <= state_d;
            lk_req_q    <= lk_req_d;
            lk_tag_q    <= lk_tag_d;
            ev_valid_q  <= ev_valid_d;
            ev_tag_q    <= ev_tag_d;
            ev_data_q   <= ev_data_d;
            ev_dirty_q  <= ev_dirty_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            busy_q      <= busy_d;
            resp_q      <= resp_d;
            hit_q       <= hit_d;
            hit_data_q  <= hit_data_d;
            hit_dirty_q <= hit_dirty_d;
            wb_write_q  <= wb_write_d;
            wb_tag_q    <= wb_tag_d;
            wb_data_q   <= wb_data_d;
            slot_q      <= slot_d;
            tag_q       <= tag_d;
            age_q       <= age_d;
        end
    end

    assign vc.busy         = busy_q;
    assign vc.resp         = resp_q;
    assign vc.lookup_hit   = hit_q;
    assign vc.lookup_data  = hit_data_q;
    assign vc.lookup_dirty = hit_dirty_q;
    assign vc.wb_write     = wb_write_q;
    assign vc.wb_tag       = wb_tag_q;
    assign vc.wb_data      = wb_data_q;

endmodule

// File: tb/tb_victim_cache.sv
// Self-checking bench for victim_cache: directed scenarios plus randomized
// transactions against a slot/LRU-list reference model.
module tb_victim_cache;

    localparam int W  = 128;
    localparam int D  = 8;
    localparam int TW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    victim_cache_if #(.WIDTH(W), .TAG_W(TW)) vc ();

    victim_cache #(.WIDTH(W), .DEPTH(D), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .vc  (vc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents plus recency list (front = most recent).
    bit            m_valid [D];
    bit            m_dirty [D];
    logic [TW-1:0] m_tag   [D];
    logic [W-1:0]  m_data  [D];
    int            m_order [$];

    bit            e_hit, e_dirty, e_wb;
    logic [W-1:0]  e_data, e_wb_data;
    logic [TW-1:0] e_wb_tag;

    bit            o_busy1, o_hit, o_dirty, o_idle_after, o_wb_stable;
    int            o_resp_cyc, o_wb_cycles;
    logic [W-1:0]  o_data, o_wb_data;
    logic [TW-1:0] o_wb_tag;

    function automatic logic [W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_reset();
        m_order.delete();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            m_order.push_back(i);
        end
    endfunction

    function automatic void touch(int s, bit to_front);
        for (int k = 0; k < m_order.size(); k++) begin
            if (m_order[k] == s) begin
                m_order.delete(k);
                break;
            end
        end
        if (to_front) m_order.push_front(s);
        else          m_order.push_back(s);
    endfunction

    function automatic int find(logic [TW-1:0] t);
        for (int i = 0; i < D; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic void model_txn(bit lk, logic [TW-1:0] lt, bit ev, logic [TW-1:0] et,
                                      logic [W-1:0] ed, bit edirty);
        int h, s;
        e_hit = 0; e_data = '0; e_dirty = 0; e_wb = 0; e_wb_tag = '0; e_wb_data = '0;
        h = lk ? find(lt) : -1;
        if (h >= 0) begin
            e_hit = 1; e_data = m_data[h]; e_dirty = m_dirty[h];
            if (ev) begin
                m_tag[h] = et; m_data[h] = ed; m_dirty[h] = edirty; touch(h, 1);
            end else begin
                m_valid[h] = 0; m_dirty[h] = 0; touch(h, 0);
            end
        end else if (ev) begin
            s = find(et);
            if (s >= 0) begin
                m_dirty[s] = m_dirty[s] | edirty;
            end else begin
                for (int i = D - 1; i >= 0; i--) if (!m_valid[i]) s = i;
                if (s < 0) begin
                    s = m_order[$];
                    if (m_dirty[s]) begin
                        e_wb = 1; e_wb_tag = m_tag[s]; e_wb_data = m_data[s];
                    end
                end
                m_dirty[s] = edirty;
            end
            m_valid[s] = 1; m_tag[s] = et; m_data[s] = ed; touch(s, 1);
        end
    endfunction

    // Drives one request and records what the DUT did; cycle 1 = first cycle after the sampling edge.
    task automatic run_txn(input bit lk, input logic [TW-1:0] lt, input bit ev, input logic [TW-1:0] et,
                           input logic [W-1:0] ed, input bit edirty, input int wb_delay, input bit pulse_busy);
        int cyc, n;
        n = 0;
        while (vc.busy && n < 50) begin @(negedge clk); n++; end
        vc.lookup_req = lk; vc.lookup_tag = lt; vc.evict_valid = ev;
        vc.evict_tag = et; vc.evict_data = ed; vc.evict_dirty = edirty;
        @(posedge clk);
        @(negedge clk);
        o_busy1 = vc.busy;
        if (pulse_busy) begin
            vc.lookup_req = 1; vc.evict_valid = 1; vc.evict_tag = 12'h7FF;
            vc.evict_data = rand_line(); vc.evict_dirty = 1;
        end else begin
            vc.lookup_req = 0; vc.evict_valid = 0;
        end
        o_resp_cyc = 0; o_wb_cycles = 0; o_wb_stable = 1;
        o_hit = 0; o_dirty = 0; o_data = '0; o_wb_tag = '0; o_wb_data = '0;
        cyc = 1;
        while (cyc < 40) begin
            if (vc.resp) begin
                o_resp_cyc = cyc; o_hit = vc.lookup_hit; o_data = vc.lookup_data; o_dirty = vc.lookup_dirty;
                break;
            end
            if (vc.wb_write) begin
                if (o_wb_cycles == 0) begin
                    o_wb_tag = vc.wb_tag; o_wb_data = vc.wb_data;
                end else if (vc.wb_tag !== o_wb_tag || vc.wb_data !== o_wb_data) begin
                    o_wb_stable = 0;
                end
                o_wb_cycles++;
                if (o_wb_cycles == wb_delay) vc.wb_resp = 1;
            end
            @(negedge clk);
            vc.wb_resp = 0;
            cyc++;
        end
        vc.lookup_req = 0; vc.evict_valid = 0;
        @(negedge clk);
        o_idle_after = !vc.busy && !vc.resp && !vc.wb_write;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        vc.lookup_req = 0; vc.evict_valid = 0; vc.wb_resp = 0;
        vc.lookup_tag = '0; vc.evict_tag = '0; vc.evict_data = '0; vc.evict_dirty = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (vc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", vc.busy); end
        checks++; if (vc.resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", vc.resp); end
        checks++; if (vc.lookup_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", vc.lookup_hit); end
        checks++; if (vc.lookup_dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty: got %b want 0", vc.lookup_dirty); end
        checks++; if (vc.wb_write !== 1'b0) begin errors++; $display("FAIL reset_wb_write: got %b want 0", vc.wb_write); end
        checks++; if (vc.lookup_data !== '0) begin errors++; $display("FAIL reset_lookup_data: got %h want 0", vc.lookup_data); end
        checks++; if (vc.wb_tag !== '0) begin errors++; $display("FAIL reset_wb_tag: got %h want 0", vc.wb_tag); end
        checks++; if (vc.wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", vc.wb_data); end
        rst = 0;
        model_reset();
    endtask

    task automatic test_miss();
        model_txn(1, 12'h123, 0, '0, '0, 0);
        run_txn(1, 12'h123, 0, '0, '0, 0, 1, 0);
        checks++; if (o_busy1 !== 1'b1) begin errors++; $display("FAIL miss_busy: got %b want 1", o_busy1); end
        checks++; if (o_resp_cyc != 2) begin errors++; $display("FAIL miss_resp_cycle: got %0d want 2", o_resp_cyc); end
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", o_hit); end
        checks++; if (o_idle_after !== 1'b1) begin errors++; $display("FAIL miss_idle_after: got %b want 1", o_idle_after); end
    endtask

    task automatic test_fill_lru();
        logic [W-1:0] d20;
        for (int t = 'h010; t <= 'h017; t++) begin
            model_txn(0, '0, 1, TW'(t), rand_line(), 0);
            run_txn(0, '0, 1, TW'(t), m_data[find(TW'(t))], 0, 1, 0);
            checks++; if (o_resp_cyc != 2 || o_wb_cycles != 0) begin
                errors++; $display("FAIL fill_install: tag %h resp_cycle %0d wb_cycles %0d want 2/0", t, o_resp_cyc, o_wb_cycles);
            end
        end
        d20 = rand_line();
        model_txn(0, '0, 1, 12'h020, d20, 0);
        run_txn(0, '0, 1, 12'h020, d20, 0, 1, 0);
        checks++; if (o_wb_cycles != 0 || o_resp_cyc != 2) begin
            errors++; $display("FAIL lru_replace: wb_cycles %0d resp_cycle %0d want 0/2", o_wb_cycles, o_resp_cyc);
        end
        model_txn(1, 12'h010, 0, '0, '0, 0);
        run_txn(1, 12'h010, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL lru_victim_gone: hit %b want 0", o_hit); end
        model_txn(1, 12'h020, 0, '0, '0, 0);
        run_txn(1, 12'h020, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b1 || o_data !== d20) begin
            errors++; $display("FAIL lru_new_line: hit %b data %h want 1/%h", o_hit, o_data, d20);
        end
    endtask

    task automatic test_writeback();
        logic [W-1:0] aa;
        aa = {16{8'hAA}};
        do_reset();
        model_txn(0, '0, 1, 12'h050, aa, 1);
        run_txn(0, '0, 1, 12'h050, aa, 1, 1, 0);
        for (int t = 'h011; t <= 'h017; t++) begin
            model_txn(0, '0, 1, TW'(t), rand_line(), (t == 'h011));
            run_txn(0, '0, 1, TW'(t), m_data[find(TW'(t))], (t == 'h011), 1, 0);
        end
        model_txn(0, '0, 1, 12'h060, rand_line(), 0);
        run_txn(0, '0, 1, 12'h060, m_data[find(12'h060)], 0, 3, 0);
        checks++; if (o_wb_cycles != 3) begin errors++; $display("FAIL wb_cycles: got %0d want 3", o_wb_cycles); end
        checks++; if (o_wb_tag !== 12'h050) begin errors++; $display("FAIL wb_tag: got %h want 050", o_wb_tag); end
        checks++; if (o_wb_data !== aa) begin errors++; $display("FAIL wb_data: got %h want %h", o_wb_data, aa); end
        checks++; if (o_wb_stable !== 1'b1) begin errors++; $display("FAIL wb_stable: got %b want 1", o_wb_stable); end
        checks++; if (o_resp_cyc != 5) begin errors++; $display("FAIL wb_resp_cycle: got %0d want 5", o_resp_cyc); end
        checks++; if (o_idle_after !== 1'b1) begin errors++; $display("FAIL wb_idle_after: got %b want 1", o_idle_after); end
    endtask

    task automatic test_swap();
        logic [W-1:0] old11, d99;
        old11 = m_data[find(12'h011)];
        d99 = rand_line();
        model_txn(1, 12'h011, 1, 12'h099, d99, 0);
        run_txn(1, 12'h011, 1, 12'h099, d99, 0, 1, 0);
        checks++; if (o_hit !== 1'b1 || o_data !== old11 || o_dirty !== 1'b1) begin
            errors++; $display("FAIL swap_result: hit %b dirty %b data %h want 1/1/%h", o_hit, o_dirty, o_data, old11);
        end
        checks++; if (o_wb_cycles != 0 || o_resp_cyc != 2) begin
            errors++; $display("FAIL swap_no_wb: wb_cycles %0d resp_cycle %0d want 0/2", o_wb_cycles, o_resp_cyc);
        end
        model_txn(1, 12'h099, 0, '0, '0, 0);
        run_txn(1, 12'h099, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b1 || o_data !== d99 || o_dirty !== 1'b0) begin
            errors++; $display("FAIL swap_installed: hit %b dirty %b data %h want 1/0/%h", o_hit, o_dirty, o_data, d99);
        end
    endtask

    task automatic test_same_tag();
        logic [W-1:0] old13, d13;
        old13 = m_data[find(12'h013)];
        d13 = rand_line();
        model_txn(1, 12'h013, 1, 12'h013, d13, 1);
        run_txn(1, 12'h013, 1, 12'h013, d13, 1, 1, 0);
        checks++; if (o_hit !== 1'b1 || o_data !== old13 || o_dirty !== 1'b0) begin
            errors++; $display("FAIL same_tag_old: hit %b dirty %b data %h want 1/0/%h", o_hit, o_dirty, o_data, old13);
        end
        model_txn(1, 12'h013, 0, '0, '0, 0);
        run_txn(1, 12'h013, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b1 || o_data !== d13 || o_dirty !== 1'b1) begin
            errors++; $display("FAIL same_tag_new: hit %b dirty %b data %h want 1/1/%h", o_hit, o_dirty, o_data, d13);
        end
    endtask

    task automatic test_merge_dirty();
        logic [W-1:0] dy;
        model_txn(0, '0, 1, 12'h014, rand_line(), 1);
        run_txn(0, '0, 1, 12'h014, m_data[find(12'h014)], 1, 1, 0);
        dy = rand_line();
        model_txn(0, '0, 1, 12'h014, dy, 0);
        run_txn(0, '0, 1, 12'h014, dy, 0, 1, 0);
        checks++; if (o_wb_cycles != 0) begin errors++; $display("FAIL merge_no_wb: got %0d want 0", o_wb_cycles); end
        model_txn(1, 12'h014, 0, '0, '0, 0);
        run_txn(1, 12'h014, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b1 || o_data !== dy || o_dirty !== 1'b1) begin
            errors++; $display("FAIL merge_dirty: hit %b dirty %b data %h want 1/1/%h", o_hit, o_dirty, o_data, dy);
        end
    endtask

    task automatic test_hit_invalidate();
        logic [W-1:0] d12;
        d12 = m_data[find(12'h012)];
        model_txn(1, 12'h012, 0, '0, '0, 0);
        run_txn(1, 12'h012, 0, '0, '0, 0, 1, 1);
        checks++; if (o_hit !== 1'b1 || o_data !== d12) begin
            errors++; $display("FAIL hit_return: hit %b data %h want 1/%h", o_hit, o_data, d12);
        end
        model_txn(1, 12'h012, 0, '0, '0, 0);
        run_txn(1, 12'h012, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL hit_removed: hit %b want 0", o_hit); end
        model_txn(1, 12'h7FF, 0, '0, '0, 0);
        run_txn(1, 12'h7FF, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL busy_pulse_ignored: hit %b want 0", o_hit); end
    endtask

    task automatic test_random(input int n);
        bit lk, ev, ed, pb;
        logic [TW-1:0] lt, et;
        logic [W-1:0] dat;
        int dly, exp_cyc;
        for (int k = 0; k < n; k++) begin
            lk = 1'($urandom_range(0, 1)); ev = 1'($urandom_range(0, 1));
            if (!lk && !ev) ev = 1;
            lt = TW'(32'h300 + $urandom_range(0, 11)); et = TW'(32'h300 + $urandom_range(0, 11));
            ed = 1'($urandom_range(0, 1)); pb = ($urandom_range(0, 7) == 0);
            dat = rand_line(); dly = $urandom_range(1, 4);
            model_txn(lk, lt, ev, et, dat, ed);
            run_txn(lk, lt, ev, et, dat, ed, dly, pb);
            exp_cyc = e_wb ? 2 + dly : 2;
            checks++; if (o_resp_cyc != exp_cyc) begin errors++; $display("FAIL rnd_resp_cycle[%0d]: got %0d want %0d", k, o_resp_cyc, exp_cyc); end
            checks++; if (o_hit !== e_hit) begin errors++; $display("FAIL rnd_hit[%0d]: got %b want %b", k, o_hit, e_hit); end
            if (e_hit) begin
                checks++; if (o_data !== e_data || o_dirty !== e_dirty) begin
                    errors++; $display("FAIL rnd_line[%0d]: data %h dirty %b want %h/%b", k, o_data, o_dirty, e_data, e_dirty);
                end
            end
            checks++; if (o_wb_cycles != (e_wb ? dly : 0)) begin errors++; $display("FAIL rnd_wb_cycles[%0d]: got %0d want %0d", k, o_wb_cycles, e_wb ? dly : 0); end
            if (e_wb) begin
                checks++; if (o_wb_tag !== e_wb_tag || o_wb_data !== e_wb_data || !o_wb_stable) begin
                    errors++; $display("FAIL rnd_wb_line[%0d]: tag %h data %h stable %b want %h/%h/1", k, o_wb_tag, o_wb_data, o_wb_stable, e_wb_tag, e_wb_data);
                end
            end
            checks++; if (o_idle_after !== 1'b1) begin errors++; $display("FAIL rnd_idle_after[%0d]: got %b want 1", k, o_idle_after); end
        end
    endtask

    task automatic test_reset_in_wb();
        do_reset();
        for (int t = 'h400; t <= 'h407; t++) begin
            model_txn(0, '0, 1, TW'(t), rand_line(), 1);
            run_txn(0, '0, 1, TW'(t), m_data[find(TW'(t))], 1, 1, 0);
        end
        vc.evict_valid = 1; vc.evict_tag = 12'h408; vc.evict_data = rand_line(); vc.evict_dirty = 0;
        @(posedge clk);
        @(negedge clk);
        vc.evict_valid = 0;
        @(negedge clk);
        checks++; if (vc.wb_write !== 1'b1 || vc.wb_tag !== 12'h400) begin
            errors++; $display("FAIL rst_wb_pre: wb_write %b wb_tag %h want 1/400", vc.wb_write, vc.wb_tag);
        end
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (vc.wb_write !== 1'b0 || vc.busy !== 1'b0) begin
            errors++; $display("FAIL rst_wb_drop: wb_write %b busy %b want 0/0", vc.wb_write, vc.busy);
        end
        rst = 0;
        model_reset();
        model_txn(1, 12'h401, 0, '0, '0, 0);
        run_txn(1, 12'h401, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b0 || o_resp_cyc != 2) begin
            errors++; $display("FAIL rst_wb_cleared: hit %b resp_cycle %0d want 0/2", o_hit, o_resp_cyc);
        end
        model_txn(1, 12'h408, 0, '0, '0, 0);
        run_txn(1, 12'h408, 0, '0, '0, 0, 1, 0);
        checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL rst_wb_discard: hit %b want 0", o_hit); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_fill_lru();
        test_writeback();
        test_swap();
        test_same_tag();
        test_merge_dirty();
        test_hit_invalidate();
        test_random(200);
        test_reset_in_wb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
